// File: rtl/click_pipe.sv
// N-stage 2-phase click pipeline built from synchronous phase/data registers.
// Define CLICK_STAT_EN to enable the saturating output transfer counter o_xfer_cnt.
module click_pipe #(
   parameter int DW      = 8,
   parameter int STAGES  = 4,
   parameter int REQ_DLY = 0,
   parameter int CNT_W   = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_reqL,
   input  logic [DW-1:0]     i_dataL,
   output logic              o_ackL,
   output logic              o_reqR,
   output logic [DW-1:0]     o_dataR,
   input  logic              i_ackR,
   output logic [STAGES-1:0] o_click,
   output logic [CNT_W-1:0]  o_xfer_cnt
);

   logic [STAGES-1:0] p;
   logic [STAGES-1:0] req_vis;
   logic [STAGES-1:0] req_in;
   logic [STAGES-1:0] ack_in;
   logic [STAGES-1:0] fire;
   logic [DW-1:0]     data    [STAGES];
   logic [DW-1:0]     data_in [STAGES];

   // Neighbour wiring: request/data from the left, ack from the right.
   always_comb begin
      req_in     = STAGES'({req_vis, i_reqL});
      ack_in     = STAGES'({i_ackR, p} >> 1);
      fire       = (req_in ^ p) & ~(ack_in ^ p);
      data_in[0] = i_dataL;
      for (int k = 1; k < STAGES; k++) begin
         data_in[k] = data[k-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         p       <= '0;
         o_click <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data[k] <= '0;
         end
      end else begin
         p       <= p ^ fire;
         o_click <= fire;
         for (int k = 0; k < STAGES; k++) begin
            if (fire[k]) begin
               data[k] <= data_in[k];
            end
         end
      end
   end

   generate
      if (REQ_DLY == 0) begin : g_no_dly
         assign req_vis = p;
      end else begin : g_dly
         logic [3:0] dly_cnt [STAGES];

         // Matched-delay emulation: the new phase is published downstream
         // only once the per-stage timer expires.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               req_vis <= '0;
               for (int k = 0; k < STAGES; k++) begin
                  dly_cnt[k] <= '0;
               end
            end else begin
               for (int k = 0; k < STAGES; k++) begin
                  if (fire[k]) begin
                     dly_cnt[k] <= 4'(REQ_DLY);
                  end else if (dly_cnt[k] != 4'd0) begin
                     dly_cnt[k] <= dly_cnt[k] - 4'd1;
                     if (dly_cnt[k] == 4'd1) begin
                        req_vis[k] <= p[k];
                     end
                  end
               end
            end
         end
      end
   endgenerate

   assign o_ackL  = p[0];
   assign o_reqR  = req_vis[STAGES-1];
   assign o_dataR = data[STAGES-1];

`ifdef CLICK_STAT_EN
   logic [CNT_W-1:0] xfer_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         xfer_cnt <= '0;
      end else if (fire[STAGES-1] && (xfer_cnt != {CNT_W{1'b1}})) begin
         xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end

   assign o_xfer_cnt = xfer_cnt;
`else
   assign o_xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_click_pipe.sv
// Self-checking bench for click_pipe: directed protocol scenarios plus randomized
// streaming against a token-queue reference model.
module tb_click_pipe;

   localparam int A_STAGES = 4;
   localparam int A_CNT_W  = 4;
   localparam int B_STAGES = 2;
   localparam int B_DLY    = 3;
`ifdef CLICK_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   logic clk;
   logic rst;

   logic                a_reqL, a_ackL, a_reqR, a_ackR;
   logic [7:0]          a_dataL, a_dataR;
   logic [A_STAGES-1:0] a_click;
   logic [A_CNT_W-1:0]  a_cnt;

   logic                b_reqL, b_ackL, b_reqR, b_ackR;
   logic [7:0]          b_dataL, b_dataR;
   logic [B_STAGES-1:0] b_click;
   logic [15:0]         b_cnt;

   int checks = 0;
   int errors = 0;

   click_pipe #(.DW(8), .STAGES(A_STAGES), .REQ_DLY(0), .CNT_W(A_CNT_W)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_reqL(a_reqL), .i_dataL(a_dataL), .o_ackL(a_ackL),
      .o_reqR(a_reqR), .o_dataR(a_dataR), .i_ackR(a_ackR), .o_click(a_click),
      .o_xfer_cnt(a_cnt)
   );

   click_pipe #(.DW(8), .STAGES(B_STAGES), .REQ_DLY(B_DLY), .CNT_W(16)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_reqL(b_reqL), .i_dataL(b_dataL), .o_ackL(b_ackL),
      .o_reqR(b_reqR), .o_dataR(b_dataR), .i_ackR(b_ackR), .o_click(b_click),
      .o_xfer_cnt(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_a_ackL"},  32'(a_ackL),  32'd0);
      chk({tag, "_a_reqR"},  32'(a_reqR),  32'd0);
      chk({tag, "_a_dataR"}, 32'(a_dataR), 32'd0);
      chk({tag, "_a_click"}, 32'(a_click), 32'd0);
      chk({tag, "_a_cnt"},   32'(a_cnt),   32'd0);
      chk({tag, "_b_ackL"},  32'(b_ackL),  32'd0);
      chk({tag, "_b_reqR"},  32'(b_reqR),  32'd0);
      chk({tag, "_b_dataR"}, 32'(b_dataR), 32'd0);
      chk({tag, "_b_click"}, 32'(b_click), 32'd0);
      chk({tag, "_b_cnt"},   32'(b_cnt),   32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_reqL = 1'b0; a_ackR = 1'b0; a_dataL = 8'h00;
      b_reqL = 1'b0; b_ackR = 1'b0; b_dataL = 8'h00;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Present one token to dut_a and wait (bounded) for its acknowledge.
   task automatic send_a(input logic [7:0] d, input int lim, output bit ok);
      a_dataL = d;
      a_reqL  = ~a_reqL;
      for (int i = 0; i < lim; i++) begin
         tick();
         if (a_ackL == a_reqL) break;
      end
      ok = (a_ackL == a_reqL);
   endtask

   // Concurrent producer/consumer on dut_a; the model is a FIFO of sent tokens.
   task automatic run_stream(input int n, input int max_gap, input int cyc_limit);
      logic [7:0] q[$];
      logic [7:0] d;
      logic       last_ack;
      int sent, acc, got, cyc, pgap, cgap, exp_cnt;
      sent = 0; acc = 0; got = 0; cyc = 0;
      pgap = $urandom_range(0, max_gap);
      cgap = $urandom_range(0, max_gap);
      last_ack = a_ackL;
      while (got < n && cyc < cyc_limit) begin
         if (a_ackL != last_ack) begin
            acc++;
            last_ack = a_ackL;
         end
         chk("occupancy", 32'((acc - got) <= A_STAGES), 32'd1);
         chk("click_adjacent", 32'(a_click & (a_click >> 1)), 32'd0);
         if (a_reqR != a_ackR) begin
            if (cgap == 0) begin
               chk("spurious_reqR", 32'(q.size() > 0), 32'd1);
               if (q.size() > 0) chk("data_order", 32'(a_dataR), 32'(q.pop_front()));
               got++;
               exp_cnt = STAT ? ((got > (1 << A_CNT_W) - 1) ? (1 << A_CNT_W) - 1 : got) : 0;
               chk("xfer_cnt", 32'(a_cnt), 32'(exp_cnt));
               a_ackR = ~a_ackR;
               cgap = $urandom_range(0, max_gap);
            end else begin
               cgap--;
            end
         end
         if (a_ackL == a_reqL && sent < n) begin
            if (pgap == 0) begin
               d = 8'($urandom);
               a_dataL = d;
               q.push_back(d);
               a_reqL = ~a_reqL;
               sent++;
               pgap = $urandom_range(0, max_gap);
            end else begin
               pgap--;
            end
         end
         tick();
         cyc++;
      end
      chk("stream_delivered", 32'(got), 32'(n));
      if (max_gap == 0) chk("throughput", 32'(cyc <= 2 * n + 2 * A_STAGES + 4), 32'd1);
   endtask

   initial begin
      bit ok;
      int n, sent;
      logic [7:0] exp_d;

      // 1: reset with random inputs
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a_reqL = 1'($urandom); a_ackR = 1'($urandom); a_dataL = 8'($urandom);
         b_reqL = 1'($urandom); b_ackR = 1'($urandom); b_dataL = 8'($urandom);
         tick();
         chk_all_zero("reset");
      end
      a_reqL = 1'b0; a_ackR = 1'b0; b_reqL = 1'b0; b_ackR = 1'b0;
      rst = 1'b0;
      tick();

      // 2: single token walks through four stages
      a_dataL = 8'hA5;
      a_reqL  = 1'b1;
      for (int i = 1; i <= A_STAGES; i++) begin
         tick();
         if (i == 1) chk("single_ackL", 32'(a_ackL), 32'd1);
         chk("single_click", 32'(a_click), 32'(1 << (i - 1)));
         chk("single_reqR", 32'(a_reqR), 32'(i == A_STAGES));
      end
      chk("single_dataR", 32'(a_dataR), 32'hA5);
      tick();
      chk("single_click_idle", 32'(a_click), 32'd0);
      a_ackR = 1'b1;
      tick();
      chk("single_cnt", 32'(a_cnt), STAT ? 32'd1 : 32'd0);

      // 4: matched-delay pipeline, two tokens each with full latency
      for (int k = 0; k < 2; k++) begin
         exp_d   = (k == 0) ? 8'h3C : 8'hC3;
         b_dataL = exp_d;
         b_reqL  = ~b_reqL;
         tick();
         chk("dly_ackL", 32'(b_ackL), 32'(b_reqL));
         chk("dly_click0", 32'(b_click), 32'd1);
         n = 0;
         while (b_reqR == b_ackR && n < 30) begin
            tick();
            n++;
         end
         chk("dly_latency", 32'(n), 32'((B_STAGES - 1) + B_STAGES * B_DLY));
         chk("dly_dataR", 32'(b_dataR), 32'(exp_d));
         b_ackR = ~b_ackR;
         tick();
      end

      // 3: backpressure, capacity of four tokens
      for (int i = 1; i <= 4; i++) begin
         send_a(8'(i), 10, ok);
         chk("bp_ack", 32'(ok), 32'd1);
      end
      send_a(8'h05, 10, ok);
      chk("bp_5th_stalled", 32'(ok), 32'd0);
      chk("bp_reqR_pending", 32'(a_reqR != a_ackR), 32'd1);
      chk("bp_head", 32'(a_dataR), 32'h01);
      a_ackR = ~a_ackR;
      for (int i = 0; i < 10 && a_ackL != a_reqL; i++) tick();
      chk("bp_5th_acked", 32'(a_ackL), 32'(a_reqL));
      for (int k = 2; k <= 5; k++) begin
         for (int i = 0; i < 20 && a_reqR == a_ackR; i++) tick();
         chk("bp_drain_valid", 32'(a_reqR != a_ackR), 32'd1);
         chk("bp_drain_data", 32'(a_dataR), 32'(k));
         a_ackR = ~a_ackR;
      end
      tick();

      // 5: reset in the middle of a three-token burst
      sent = 0;
      for (int c = 1; c <= 6; c++) begin
         if (a_ackL == a_reqL && sent < 3) begin
            a_dataL = 8'h10 + 8'(sent);
            a_reqL  = ~a_reqL;
            sent++;
         end
         tick();
      end
      rst = 1'b1;
      a_reqL = 1'b0; a_ackR = 1'b0; b_reqL = 1'b0; b_ackR = 1'b0;
      tick();
      chk_all_zero("midreset");
      rst = 1'b0;
      a_dataL = 8'h5A;
      a_reqL  = 1'b1;
      tick();
      chk("post_reset_ackL", 32'(a_ackL), 32'd1);
      for (int i = 1; i < A_STAGES - 1; i++) tick();
      chk("post_reset_reqR_early", 32'(a_reqR), 32'd0);
      tick();
      chk("post_reset_reqR", 32'(a_reqR), 32'd1);
      chk("post_reset_dataR", 32'(a_dataR), 32'h5A);

      // randomized streaming with random producer/consumer gaps
      do_reset();
      run_stream(40, 3, 2000);

      // 6: zero-gap stream of 20 tokens; counter saturates at 15
      do_reset();
      run_stream(20, 0, 400);
      chk("cnt_saturated", 32'(a_cnt), STAT ? 32'd15 : 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
